dmem_responder: RTL

- Data-memory responder serving the load/store port of the pipelined RISC-V core; it is the memory-side end of the core's data request/response interface.
- Accepts one request at a time over a valid/ready request channel and holds it for a programmable wait-state latency.
- Performs a byte-enabled word write or a word read on internal storage, then returns a response over a valid/ready response channel.
- Used in core testbenches and FPGA builds in place of external memory.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder : single-outstanding data-memory responder with a
// programmable wait-state latency and byte-enabled word storage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_RESP = 2'd2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam bit          DIRECT = (LATENCY == 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] mem_q [0:DEPTH_WORDS-1];

  logic        accept;
  logic        commit;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, cur_off;
  logic [3:0]  cur_be;
  logic        cur_err;
  logic [AW-1:0] cur_idx;

  assign accept = req_valid && req_ready;
  assign commit = (state_q == S_IDLE && accept && DIRECT) ||
                  (state_q == S_WAIT && cnt_q == 4'd0);

  // With LATENCY==1 the commit happens on the acceptance edge, so use the live request.
  assign cur_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == S_IDLE) ? req_be    : be_q;
  assign cur_off   = cur_addr - BASE_ADDR;
  assign cur_idx   = cur_off[AW+1:2];
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE_ADDR) ||
                     ({2'b00, cur_off[31:2]} >= 32'(DEPTH_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (DIRECT) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE) && !rst;
    busy      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else if (commit) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= cur_err;
      rsp_rdata_q <= (!cur_err && !cur_we) ? mem_q[cur_idx] : 32'd0;
    end else if (state_q == S_RESP && rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end
  end

  // Storage is deliberately not reset; a reset edge must also suppress the write.
  always_ff @(posedge clk) begin
    if (commit && !rst && !cur_err && cur_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire
